// File: rtl/huffman_pkg.sv
// Shared types and helpers for the Huffman output packer and its word FIFO.
package huffman_pkg;

  localparam int unsigned WORD_BYTES         = 8;
  localparam int unsigned DATA_W             = 8 * WORD_BYTES;
  localparam int unsigned LANE_W             = $clog2(WORD_BYTES);
  localparam int unsigned ADDR_W             = 16;
  localparam int unsigned COUNT_W            = 32;
  localparam int unsigned DEFAULT_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PACK  = 2'd1,
    DRAIN = 2'd2
  } pack_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0]     addr;
    logic [WORD_BYTES-1:0] mask;
    logic [DATA_W-1:0]     data;
  } word_entry_t;

  // Lane count 0 means a complete word; otherwise the low 'lane' bytes are valid.
  function automatic logic [WORD_BYTES-1:0] mask_from_lane(input logic [LANE_W-1:0] lane);
    logic [WORD_BYTES-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < WORD_BYTES; i++) begin
      m[i] = (lane == '0) || (i < 32'(lane));
    end
    return m;
  endfunction

endpackage

// File: rtl/huffman_word_fifo.sv
// Synchronous word FIFO; a push while full is taken only when a pop frees a slot in the same cycle.
module huffman_word_fifo
  import huffman_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  word_entry_t push_entry,
  input  logic        pop,
  output word_entry_t head,
  output logic        full,
  output logic        empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  word_entry_t      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage needs no reset: entries are only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/huffman_out_packer.sv
// Packs the Huffman Top byte stream into little-endian words and writes them out through a word FIFO.
module huffman_out_packer
  import huffman_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  io_start,
  input  logic [ADDR_W-1:0]     io_base_addr,
  input  logic                  io_in_valid,
  input  logic [7:0]            io_in_bits,
  input  logic                  io_flush,
  output logic                  io_mem_valid,
  input  logic                  io_mem_ready,
  output logic [ADDR_W-1:0]     io_mem_addr,
  output logic [DATA_W-1:0]     io_mem_data,
  output logic [WORD_BYTES-1:0] io_mem_mask,
  output logic                  io_busy,
  output logic                  io_done,
  output logic [COUNT_W-1:0]    io_byte_count,
  output logic                  io_overflow
);

  pack_state_e         state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W-1:0]   word_idx_q, word_idx_d;
  logic [COUNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0]   word_buf_q, word_buf_d;
  logic                overflow_q, overflow_d;
  logic                done_q, done_d;

  logic [LANE_W-1:0]   lane;
  logic [LANE_W-1:0]   lane_next;
  logic [DATA_W-1:0]   merged;
  logic                push;
  word_entry_t         push_entry;
  word_entry_t         head;
  logic                fifo_full;
  logic                fifo_empty;
  logic                pop;

  assign lane = count_q[LANE_W-1:0];
  assign pop  = io_mem_ready && !fifo_empty;

  huffman_word_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      base_q     <= '0;
      word_idx_q <= '0;
      count_q    <= '0;
      word_buf_q <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      word_idx_q <= word_idx_d;
      count_q    <= count_d;
      word_buf_q <= word_buf_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    word_idx_d = word_idx_q;
    count_d    = count_q;
    word_buf_d = word_buf_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;
    merged     = word_buf_q;
    lane_next  = lane;
    push       = 1'b0;
    push_entry = '0;

    unique case (state_q)
      IDLE: begin
        if (io_start) begin
          state_d    = PACK;
          base_d     = io_base_addr;
          word_idx_d = '0;
          count_d    = '0;
          word_buf_d = '0;
          overflow_d = 1'b0;
        end
      end

      PACK: begin
        if (io_in_valid) begin
          merged[{lane, 3'b000} +: 8] = io_in_bits;
          count_d   = count_q + COUNT_W'(1);
          lane_next = lane + LANE_W'(1);
        end
        word_buf_d = merged;
        // A wrapped lane means the word just completed; a flush emits whatever is left.
        if ((io_in_valid && (lane_next == '0)) || (io_flush && (lane_next != '0))) begin
          push            = 1'b1;
          push_entry.addr = base_q + word_idx_q;
          push_entry.mask = mask_from_lane(lane_next);
          push_entry.data = merged;
          word_buf_d      = '0;
          if (lane_next == '0) word_idx_d = word_idx_q + ADDR_W'(1);
        end
        if (io_flush) state_d = DRAIN;
      end

      DRAIN: begin
        if (fifo_empty) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    if (push && fifo_full && !pop) overflow_d = 1'b1;
  end

  // Head fields read as zero while nothing is queued so the port is quiet after reset.
  assign io_mem_valid  = !fifo_empty;
  assign io_mem_addr   = fifo_empty ? '0 : head.addr;
  assign io_mem_data   = fifo_empty ? '0 : head.data;
  assign io_mem_mask   = fifo_empty ? '0 : head.mask;
  assign io_busy       = (state_q != IDLE);
  assign io_done       = done_q;
  assign io_byte_count = count_q;
  assign io_overflow   = overflow_q;

endmodule

// File: tb/tb_huffman_out_packer.sv
// Self-checking bench for huffman_out_packer: directed table, corner sequences, random jobs vs a queue model.
module tb_huffman_out_packer;
  import huffman_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic                  clk;
  logic                  rst_n;
  logic                  io_start;
  logic [ADDR_W-1:0]     io_base_addr;
  logic                  io_in_valid;
  logic [7:0]            io_in_bits;
  logic                  io_flush;
  logic                  io_mem_valid;
  logic                  io_mem_ready;
  logic [ADDR_W-1:0]     io_mem_addr;
  logic [DATA_W-1:0]     io_mem_data;
  logic [WORD_BYTES-1:0] io_mem_mask;
  logic                  io_busy;
  logic                  io_done;
  logic [COUNT_W-1:0]    io_byte_count;
  logic                  io_overflow;

  huffman_out_packer #(.FIFO_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .io_start      (io_start),
    .io_base_addr  (io_base_addr),
    .io_in_valid   (io_in_valid),
    .io_in_bits    (io_in_bits),
    .io_flush      (io_flush),
    .io_mem_valid  (io_mem_valid),
    .io_mem_ready  (io_mem_ready),
    .io_mem_addr   (io_mem_addr),
    .io_mem_data   (io_mem_data),
    .io_mem_mask   (io_mem_mask),
    .io_busy       (io_busy),
    .io_done       (io_done),
    .io_byte_count (io_byte_count),
    .io_overflow   (io_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int done_seen;

  // Reference model: job mode (0 idle, 1 packing, 2 draining), bytes of the open word, queued words.
  int               mmode;
  logic [15:0]      mbase;
  logic [15:0]      mwidx;
  int unsigned      mcount;
  bit               movf;
  bit               mdone;
  logic [7:0]       cur[$];
  word_entry_t      mq[$];
  word_entry_t      got[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    mmode = 0; mbase = '0; mwidx = '0; mcount = 0; movf = 0; mdone = 0;
    cur.delete(); mq.delete();
  endtask

  function automatic word_entry_t pack_word();
    word_entry_t w;
    w.addr = 16'(mbase + mwidx);
    w.data = '0;
    for (int k = 0; k < cur.size(); k++) w.data = w.data | (64'(cur[k]) << (8 * k));
    w.mask = 8'((1 << cur.size()) - 1);
    cur.delete();
    return w;
  endfunction

  task automatic model_update();
    bit          do_pop;
    bit          do_push;
    word_entry_t w;
    do_pop  = io_mem_ready && (mq.size() > 0);
    do_push = 0;
    mdone   = 0;
    w       = '0;
    case (mmode)
      0: if (io_start) begin
        mmode = 1; mbase = io_base_addr; mwidx = '0; mcount = 0; movf = 0; cur.delete();
      end
      1: begin
        if (io_in_valid) begin
          cur.push_back(io_in_bits);
          mcount++;
          if (cur.size() == WORD_BYTES) begin
            w = pack_word(); do_push = 1; mwidx = mwidx + 16'd1;
          end
        end
        if (io_flush) begin
          if (cur.size() > 0) begin w = pack_word(); do_push = 1; end
          mmode = 2;
        end
      end
      default: if (mq.size() == 0) begin mdone = 1; mmode = 0; end
    endcase
    if (do_pop) void'(mq.pop_front());
    if (do_push) begin
      if (mq.size() < DEPTH) mq.push_back(w);
      else movf = 1;
    end
  endtask

  // One clock: compare DUT to model at the falling edge, log the write, advance the model.
  task automatic step();
    word_entry_t e;
    @(negedge clk);
    cyc++;
    chk("mem_valid", 64'(io_mem_valid), 64'(mq.size() > 0));
    if (mq.size() > 0) begin
      chk("mem_addr", 64'(io_mem_addr), 64'(mq[0].addr));
      chk("mem_data", io_mem_data, mq[0].data);
      chk("mem_mask", 64'(io_mem_mask), 64'(mq[0].mask));
    end
    chk("busy", 64'(io_busy), 64'(mmode != 0));
    chk("done", 64'(io_done), 64'(mdone));
    chk("byte_count", 64'(io_byte_count), 64'(mcount));
    chk("overflow", 64'(io_overflow), 64'(movf));
    if (io_done) done_seen++;
    if (io_mem_valid && io_mem_ready) begin
      e.addr = io_mem_addr; e.data = io_mem_data; e.mask = io_mem_mask;
      got.push_back(e);
    end
    model_update();
    @(posedge clk);
    #1;
  endtask

  // rmode: 0 ready high, 1 ready low, 2 toggle each cycle, 3 random 70% high
  task automatic set_ready(input int rmode);
    case (rmode)
      0: io_mem_ready = 1'b1;
      1: io_mem_ready = 1'b0;
      2: io_mem_ready = ~io_mem_ready;
      default: io_mem_ready = ($urandom_range(0, 99) < 70);
    endcase
  endtask

  task automatic start_job(input logic [15:0] base, input int rmode);
    io_start = 1'b1; io_base_addr = base; set_ready(rmode);
    step();
    io_start = 1'b0;
  endtask

  task automatic feed(input int n, input logic [7:0] first, input bit rnd, input bit flush_last,
                      input int rmode, input int gap_pct);
    for (int i = 0; i < n; i++) begin
      while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        io_in_valid = 1'b0; io_flush = 1'b0; set_ready(rmode); step();
      end
      io_in_valid = 1'b1;
      io_in_bits  = rnd ? 8'($urandom) : 8'(first + 8'(i));
      io_flush    = flush_last && (i == n - 1);
      io_start    = rnd && ($urandom_range(0, 15) == 0);
      if (io_start) io_base_addr = 16'($urandom);
      set_ready(rmode);
      step();
    end
    io_in_valid = 1'b0; io_flush = 1'b0; io_start = 1'b0;
  endtask

  task automatic finish_job(input bit need_flush, input int rmode);
    if (need_flush) begin
      io_flush = 1'b1; set_ready(rmode); step(); io_flush = 1'b0;
    end
    for (int k = 0; k < 400 && mmode != 0; k++) begin
      set_ready(rmode); step();
    end
    if (mmode != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout cycle=%0d actual=busy expected=idle", cyc);
      model_reset();
    end
    set_ready(rmode);
    step();
  endtask

  typedef struct {
    logic [15:0] base;
    int          n;
    logic [7:0]  first;
    bit          fwl;
    int          nw;
    logic [15:0] a0;
    logic [63:0] d0;
    logic [7:0]  m0;
    logic [15:0] al;
    logic [63:0] dl;
    logic [7:0]  ml;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{16'h0010, 16, 8'h00, 1'b0, 2, 16'h0010, 64'h0706050403020100, 8'hFF,
               16'h0011, 64'h0F0E0D0C0B0A0908, 8'hFF};
    tbl[1] = '{16'h0100, 11, 8'hA0, 1'b1, 2, 16'h0100, 64'hA7A6A5A4A3A2A1A0, 8'hFF,
               16'h0101, 64'h0000000000AAA9A8, 8'h07};
    tbl[2] = '{16'hFFFF, 16, 8'h30, 1'b0, 2, 16'hFFFF, 64'h3736353433323130, 8'hFF,
               16'h0000, 64'h3F3E3D3C3B3A3938, 8'hFF};
    tbl[3] = '{16'h0200, 0, 8'h00, 1'b0, 0, 16'h0, 64'h0, 8'h0, 16'h0, 64'h0, 8'h0};
    tbl[4] = '{16'h0300, 8, 8'h50, 1'b1, 1, 16'h0300, 64'h5756555453525150, 8'hFF,
               16'h0300, 64'h5756555453525150, 8'hFF};
    tbl[5] = '{16'h0400, 1, 8'hC3, 1'b0, 1, 16'h0400, 64'h00000000000000C3, 8'h01,
               16'h0400, 64'h00000000000000C3, 8'h01};

    rst_n = 1'b0; io_start = 1'b0; io_base_addr = '0; io_in_valid = 1'b0;
    io_in_bits = '0; io_flush = 1'b0; io_mem_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_valid", 64'(io_mem_valid), 64'd0);
    chk("rst_mem_addr", 64'(io_mem_addr), 64'd0);
    chk("rst_mem_data", io_mem_data, 64'd0);
    chk("rst_mem_mask", 64'(io_mem_mask), 64'd0);
    chk("rst_busy", 64'(io_busy), 64'd0);
    chk("rst_done", 64'(io_done), 64'd0);
    chk("rst_byte_count", 64'(io_byte_count), 64'd0);
    chk("rst_overflow", 64'(io_overflow), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed table with ready held high
    foreach (tbl[t]) begin
      got.delete(); done_seen = 0;
      start_job(tbl[t].base, 0);
      feed(tbl[t].n, tbl[t].first, 1'b0, tbl[t].fwl, 0, 0);
      finish_job(!tbl[t].fwl, 0);
      chk("tbl_nwrites", 64'(got.size()), 64'(tbl[t].nw));
      chk("tbl_count", 64'(io_byte_count), 64'(tbl[t].n));
      chk("tbl_done_pulses", 64'(done_seen), 64'd1);
      if (tbl[t].nw > 0 && got.size() == tbl[t].nw) begin
        chk("tbl_addr0", 64'(got[0].addr), 64'(tbl[t].a0));
        chk("tbl_data0", got[0].data, tbl[t].d0);
        chk("tbl_mask0", 64'(got[0].mask), 64'(tbl[t].m0));
        chk("tbl_addrl", 64'(got[tbl[t].nw-1].addr), 64'(tbl[t].al));
        chk("tbl_datal", got[tbl[t].nw-1].data, tbl[t].dl);
        chk("tbl_maskl", 64'(got[tbl[t].nw-1].mask), 64'(tbl[t].ml));
      end
    end

    // Overflow: five words against a stalled four-entry FIFO, fifth word lost
    got.delete();
    start_job(16'h0500, 1);
    feed(39, 8'h00, 1'b0, 1'b0, 1, 0);
    chk("ovf_before_word5", 64'(io_overflow), 64'd0);
    feed(1, 8'h27, 1'b0, 1'b0, 1, 0);
    chk("ovf_after_word5", 64'(io_overflow), 64'd1);
    chk("ovf_count", 64'(io_byte_count), 64'd40);
    finish_job(1'b1, 0);
    chk("ovf_nwrites", 64'(got.size()), 64'd4);
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      chk("ovf_addr", 64'(got[i].addr), 64'(16'h0500 + 16'(i)));
      chk("ovf_byte0", 64'(got[i].data[7:0]), 64'(8 * i));
    end
    chk("ovf_sticky", 64'(io_overflow), 64'd1);

    // Ready toggling every cycle: head held while stalled, nothing lost, addresses in order
    got.delete();
    io_mem_ready = 1'b0;
    start_job(16'h0600, 2);
    feed(24, 8'h10, 1'b0, 1'b0, 2, 0);
    finish_job(1'b1, 2);
    chk("tog_nwrites", 64'(got.size()), 64'd3);
    for (int i = 0; i < 3 && i < got.size(); i++)
      chk("tog_addr", 64'(got[i].addr), 64'(16'h0600 + 16'(i)));

    // Asynchronous reset mid-PACK with two words queued
    start_job(16'h0700, 1);
    feed(19, 8'h60, 1'b0, 1'b0, 1, 0);
    chk("pre_rst_valid", 64'(io_mem_valid), 64'd1);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_valid", 64'(io_mem_valid), 64'd0);
    chk("mid_rst_busy", 64'(io_busy), 64'd0);
    chk("mid_rst_count", 64'(io_byte_count), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    got.delete();
    for (int i = 0; i < 6; i++) begin set_ready(0); step(); end
    chk("post_rst_nwrites", 64'(got.size()), 64'd0);

    // Random jobs with gaps, noise pulses and random backpressure
    for (int j = 0; j < 30; j++) begin
      int n;
      bit fl;
      n  = $urandom_range(0, 40);
      fl = (n > 0) && ($urandom_range(0, 1) == 1);
      io_in_valid = 1'b1; io_flush = 1'b1; io_in_bits = 8'($urandom);
      set_ready(3); step();
      io_in_valid = 1'b0; io_flush = 1'b0;
      start_job(16'($urandom), 3);
      feed(n, 8'h00, 1'b1, fl, 3, 20);
      finish_job(!fl, 3);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
